// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator car controller and its tick synchroniser.
package elevator_pkg;

    localparam int DEF_N_FLOORS    = 4;
    localparam int DEF_FLOOR_W     = 2;
    localparam int DEF_DOOR_SECS   = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int TIMER_W         = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_t;

endpackage

// File: rtl/tick_sync.sv
// Brings the slow clk_1Hz into the system clock domain as data and emits one
// registered single-cycle tick per rising edge (SYNC_STAGES+1 cycles after the edge).
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic async_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], async_in};
            prev <= sync[SYNC_STAGES-1];
            tick <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car motion/door controller: latches floor requests, serves them in SCAN
// order one floor per tick, and holds the door open for DOOR_SECS ticks.
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = DEF_N_FLOORS,
    parameter int FLOOR_W     = DEF_FLOOR_W,
    parameter int DOOR_SECS   = DEF_DOOR_SECS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic                clk_1Hz,
    input  logic [N_FLOORS-1:0] floor_req,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                moving,
    output logic                dir_up,
    output logic                door_open
);

    state_t               state;
    state_t               state_next;
    logic [FLOOR_W-1:0]   cur_next;
    logic                 dir_next;
    logic [TIMER_W-1:0]   door_timer;
    logic [TIMER_W-1:0]   timer_next;
    logic [N_FLOORS-1:0]  want;
    logic [N_FLOORS-1:0]  clr;
    logic [FLOOR_W-1:0]   up_floor;
    logic [FLOOR_W-1:0]   dn_floor;
    logic                 at_top;
    logic                 at_bottom;
    logic                 above;
    logic                 below;
    logic                 above_far;
    logic                 below_far;
    logic                 tick;

    tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .async_in  (clk_1Hz),
        .tick      (tick)
    );

    // Arrival decisions also honour requests arriving in the same cycle as the tick.
    assign want      = pending | floor_req;
    assign up_floor  = current_floor + 1'b1;
    assign dn_floor  = current_floor - 1'b1;
    assign at_top    = (current_floor == FLOOR_W'(N_FLOORS - 1));
    assign at_bottom = (current_floor == '0);

    always_comb begin
        int cur_i;
        cur_i     = int'(current_floor);
        above     = 1'b0;
        below     = 1'b0;
        above_far = 1'b0;
        below_far = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > cur_i)     above     = above | pending[i];
            if (i < cur_i)     below     = below | pending[i];
            if (i > cur_i + 1) above_far = above_far | want[i];
            if (i < cur_i - 1) below_far = below_far | want[i];
        end
    end

    always_comb begin
        state_next = state;
        cur_next   = current_floor;
        dir_next   = dir_up;
        timer_next = door_timer;
        unique case (state)
            IDLE: begin
                if (pending[current_floor]) begin
                    state_next = DOOR;
                    timer_next = TIMER_W'(DOOR_SECS);
                end else if (above && (dir_up || !below)) begin
                    state_next = MOVE_UP;
                    dir_next   = 1'b1;
                end else if (below) begin
                    state_next = MOVE_DOWN;
                    dir_next   = 1'b0;
                end
            end
            MOVE_UP: begin
                if (tick) begin
                    if (at_top) begin
                        state_next = IDLE;
                    end else begin
                        cur_next = up_floor;
                        if (want[up_floor]) begin
                            state_next = DOOR;
                            timer_next = TIMER_W'(DOOR_SECS);
                        end else if (!above_far) begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            MOVE_DOWN: begin
                if (tick) begin
                    if (at_bottom) begin
                        state_next = IDLE;
                    end else begin
                        cur_next = dn_floor;
                        if (want[dn_floor]) begin
                            state_next = DOOR;
                            timer_next = TIMER_W'(DOOR_SECS);
                        end else if (!below_far) begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            DOOR: begin
                // A fresh call at this floor keeps the door open instead of being latched.
                if (floor_req[current_floor]) begin
                    timer_next = TIMER_W'(DOOR_SECS);
                end else if (tick) begin
                    timer_next = door_timer - 1'b1;
                    if (door_timer == TIMER_W'(1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        if ((state == DOOR) || (state_next == DOOR)) clr = N_FLOORS'(1) << cur_next;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state         <= IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            door_timer    <= '0;
            moving        <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_next;
            current_floor <= cur_next;
            pending       <= (pending | floor_req) & ~clr;
            dir_up        <= dir_next;
            door_timer    <= timer_next;
            moving        <= (state_next == MOVE_UP) || (state_next == MOVE_DOWN);
            door_open     <= (state_next == DOOR);
        end
    end

endmodule
